// File: rtl/spart_bus_fifo_if.sv
// SPART CPU-side register interface: RX/TX FIFOs, status/control, baud divisor, irq.
// Define SPART_BUS_DIV_READBACK_EN to make divisor bytes readable at addresses 2/3.
module spart_bus_fifo_if #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         RX_DEPTH    = 8,
  parameter int unsigned         TX_DEPTH    = 8,
  parameter logic [2*DATA_W-1:0] DEFAULT_DIV = 16'h0145
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iocs,
  input  logic                  iorw,
  input  logic [1:0]            ioaddr,
  inout  wire  [DATA_W-1:0]     databus,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [2*DATA_W-1:0]   baud_div,
  output logic                  baud_load,
  output logic                  irq
);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);

  logic              iocs_q, first, rd_first, wr_first;
  logic [DATA_W-1:0] rd_live, rd_hold, status;
  logic              rx_ie, tx_ie, rx_ovr, tx_ovr;

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wp, rx_rp;
  logic [RX_AW:0]    rx_cnt;
  logic              rx_full, rda, rx_push, rx_pop;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wp, tx_rp;
  logic [TX_AW:0]    tx_cnt;
  logic              tx_full, tx_empty, tx_push, tx_pop, tx_drop;

  assign first    = iocs & ~iocs_q;
  assign rd_first = first & iorw;
  assign wr_first = first & ~iorw;

  assign rx_full  = (rx_cnt == (RX_AW+1)'(RX_DEPTH));
  assign rda      = (rx_cnt != '0);
  assign rx_pop   = rd_first && (ioaddr == 2'd0) && rda;
  // A pop in the same cycle frees the slot a full FIFO needs for the incoming byte.
  assign rx_push  = rx_valid & (~rx_full | rx_pop);

  assign tx_full  = (tx_cnt == (TX_AW+1)'(TX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rp];
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = wr_first && (ioaddr == 2'd0) && (~tx_full || tx_pop);
  assign tx_drop  = wr_first && (ioaddr == 2'd0) && tx_full && ~tx_pop;

  always_comb begin
    status    = '0;
    status[0] = rda;
    status[1] = ~tx_full;
    status[2] = tx_empty;
    status[3] = rx_ovr;
    status[4] = tx_ovr;
  end

  always_comb begin
    rd_live = '0;
    case (ioaddr)
      2'd0: if (rda) rd_live = rx_mem[rx_rp];
      2'd1: rd_live = status;
`ifdef SPART_BUS_DIV_READBACK_EN
      2'd2: rd_live = baud_div[DATA_W-1:0];
      2'd3: rd_live = baud_div[2*DATA_W-1:DATA_W];
`else
      default: rd_live = '0;
`endif
    endcase
  end

  // Later cycles of a held read replay the first-cycle value so a popped byte stays put.
  assign databus = (iocs & iorw) ? (first ? rd_live : rd_hold) : 'z;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
    if (tx_push) tx_mem[tx_wp] <= databus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iocs_q    <= 1'b1;
      rd_hold   <= '0;
      rx_ie     <= 1'b0;
      tx_ie     <= 1'b0;
      rx_ovr    <= 1'b0;
      tx_ovr    <= 1'b0;
      baud_div  <= DEFAULT_DIV;
      baud_load <= 1'b0;
      irq       <= 1'b0;
    end else begin
      iocs_q    <= iocs;
      baud_load <= wr_first & ioaddr[1];
      irq       <= (rx_ie & rda) | (tx_ie & tx_empty) | rx_ovr | tx_ovr;
      if (rd_first) rd_hold <= rd_live;
      if (wr_first && ioaddr == 2'd1) begin
        rx_ie <= databus[0];
        tx_ie <= databus[1];
      end
      if (rx_valid && rx_full && !rx_pop)
        rx_ovr <= 1'b1;
      else if (wr_first && ioaddr == 2'd1 && databus[DATA_W-2])
        rx_ovr <= 1'b0;
      if (tx_drop)
        tx_ovr <= 1'b1;
      else if (wr_first && ioaddr == 2'd1 && databus[DATA_W-1])
        tx_ovr <= 1'b0;
      if (wr_first && ioaddr == 2'd2) baud_div[DATA_W-1:0]        <= databus;
      if (wr_first && ioaddr == 2'd3) baud_div[2*DATA_W-1:DATA_W] <= databus;
    end
  end
endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Directed self-checking bench for spart_bus_fifo_if (default parameters).
module tb_spart_bus_fifo_if;
  logic        clk = 1'b0;
  logic        rst, iocs, iorw, rx_valid, tx_ready, drv_en;
  logic [1:0]  ioaddr;
  logic [7:0]  rx_data, drv, tx_data;
  logic        tx_valid, baud_load, irq;
  logic [15:0] baud_div;
  wire  [7:0]  databus;
  int          vec = 0;
  int          errs = 0;

  assign databus = drv_en ? drv : 'z;

  spart_bus_fifo_if #(.DATA_W(8), .RX_DEPTH(8), .TX_DEPTH(8), .DEFAULT_DIV(16'h0145)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .baud_div(baud_div), .baud_load(baud_load), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1; iorw = 0; ioaddr = a; drv = d; drv_en = 1;
    tick();
    iocs = 0; drv_en = 0;
    tick();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 d = databus;
    tick();
    iocs = 0; iorw = 0;
    tick();
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_valid = 1; rx_data = d;
    tick();
    rx_valid = 0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    rst = 1; iocs = 0; iorw = 0; ioaddr = 0; drv = 0; drv_en = 0;
    rx_valid = 0; rx_data = 0; tx_ready = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    vec++; if (baud_div !== 16'h0145) begin errs++; $display("FAIL reset_div got %h want 0145", baud_div); end
    vec++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %b want 0", irq); end
    vec++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errs++; $display("FAIL reset_tx got %b/%h want 0/00", tx_valid, tx_data); end
    vec++; if (baud_load !== 1'b0) begin errs++; $display("FAIL reset_load got %b want 0", baud_load); end
    bus_read(2'd1, r);
    vec++; if (r !== 8'h06) begin errs++; $display("FAIL reset_status got %h want 06", r); end
  endtask

  task automatic test_rx_read();
    logic [7:0] r;
    logic [7:0] exp1 [3];
    exp1 = '{8'h41, 8'h41, 8'h41};
    rx_pulse(8'h41);
    rx_pulse(8'h42);
    iocs = 1; iorw = 1; ioaddr = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if (databus !== exp1[i]) begin errs++; $display("FAIL held_read[%0d] got %h want %h", i, databus, exp1[i]); end
      tick();
    end
    iocs = 0; iorw = 0;
    tick();
    bus_read(2'd0, r);
    vec++; if (r !== 8'h42) begin errs++; $display("FAIL rx_second got %h want 42", r); end
    bus_read(2'd0, r);
    vec++; if (r !== 8'h00) begin errs++; $display("FAIL rx_empty_read got %h want 00", r); end
    bus_read(2'd1, r);
    vec++; if (r !== 8'h06) begin errs++; $display("FAIL rx_empty_status got %h want 06", r); end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] r;
    tx_ready = 0;
    for (int i = 0; i < 9; i++) bus_write(2'd0, 8'h10 + 8'(i));
    bus_read(2'd1, r);
    vec++; if (r !== 8'h10) begin errs++; $display("FAIL tx_ovr_status got %h want 10", r); end
    vec++; if (irq !== 1'b1) begin errs++; $display("FAIL tx_ovr_irq got %b want 1", irq); end
    vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin errs++; $display("FAIL tx_head got %b/%h want 1/10", tx_valid, tx_data); end
    bus_write(2'd1, 8'h80);
    vec++; if (irq !== 1'b0) begin errs++; $display("FAIL tx_clr_irq got %b want 0", irq); end
    bus_read(2'd1, r);
    vec++; if (r !== 8'h00) begin errs++; $display("FAIL tx_clr_status got %h want 00", r); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [7:0] exp [8];
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    iocs = 1; iorw = 0; ioaddr = 2'd0; drv = 8'h55; drv_en = 1; tx_ready = 1;
    tick();
    iocs = 0; drv_en = 0; tx_ready = 0;
    tick();
    vec++; if (tx_data !== 8'h11) begin errs++; $display("FAIL b2b_head got %h want 11", tx_data); end
    bus_read(2'd1, r);
    vec++; if (r !== 8'h00) begin errs++; $display("FAIL b2b_status got %h want 00", r); end
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      vec++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin errs++; $display("FAIL drain[%0d] got %b/%h want 1/%h", i, tx_valid, tx_data, exp[i]); end
      tick();
    end
    tx_ready = 0;
    vec++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errs++; $display("FAIL drained got %b/%h want 0/00", tx_valid, tx_data); end
  endtask

  task automatic test_rx_full();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) rx_pulse(8'hA0 + 8'(i));
    iocs = 1; iorw = 1; ioaddr = 2'd0; rx_valid = 1; rx_data = 8'hA8;
    #1;
    vec++; if (databus !== 8'hA0) begin errs++; $display("FAIL full_pop got %h want A0", databus); end
    tick();
    iocs = 0; iorw = 0; rx_valid = 0;
    tick();
    bus_read(2'd1, r);
    vec++; if (r !== 8'h07) begin errs++; $display("FAIL full_no_ovr got %h want 07", r); end
    rx_pulse(8'hA9);
    tick();
    bus_read(2'd1, r);
    vec++; if (r !== 8'h0F) begin errs++; $display("FAIL rx_ovr_status got %h want 0F", r); end
    vec++; if (irq !== 1'b1) begin errs++; $display("FAIL rx_ovr_irq got %b want 1", irq); end
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd0, r);
      vec++; if (r !== 8'hA0 + 8'(i)) begin errs++; $display("FAIL rx_drain[%0d] got %h want %h", i, r, 8'hA0 + 8'(i)); end
    end
    bus_write(2'd1, 8'h40);
    bus_read(2'd1, r);
    vec++; if (r !== 8'h06) begin errs++; $display("FAIL rx_clr_status got %h want 06", r); end
    bus_write(2'd1, 8'h02);
    vec++; if (irq !== 1'b1) begin errs++; $display("FAIL tx_ie_irq got %b want 1", irq); end
    bus_write(2'd1, 8'h00);
    vec++; if (irq !== 1'b0) begin errs++; $display("FAIL ie_off_irq got %b want 0", irq); end
  endtask

  task automatic test_baud();
    logic [7:0] r;
    logic [7:0] exp_lo, exp_hi;
`ifdef SPART_BUS_DIV_READBACK_EN
    exp_lo = 8'h34; exp_hi = 8'h12;
`else
    exp_lo = 8'h00; exp_hi = 8'h00;
`endif
    iocs = 1; iorw = 0; ioaddr = 2'd3; drv = 8'h12; drv_en = 1;
    tick();
    iocs = 0; drv_en = 0;
    vec++; if (baud_div !== 16'h1245 || baud_load !== 1'b1) begin errs++; $display("FAIL div_hi got %h/%b want 1245/1", baud_div, baud_load); end
    tick();
    vec++; if (baud_load !== 1'b0) begin errs++; $display("FAIL load_hi_end got %b want 0", baud_load); end
    iocs = 1; iorw = 0; ioaddr = 2'd2; drv = 8'h34; drv_en = 1;
    tick();
    iocs = 0; drv_en = 0;
    vec++; if (baud_div !== 16'h1234 || baud_load !== 1'b1) begin errs++; $display("FAIL div_lo got %h/%b want 1234/1", baud_div, baud_load); end
    tick();
    vec++; if (baud_load !== 1'b0) begin errs++; $display("FAIL load_lo_end got %b want 0", baud_load); end
    bus_read(2'd2, r);
    vec++; if (r !== exp_lo) begin errs++; $display("FAIL div_rd_lo got %h want %h", r, exp_lo); end
    bus_read(2'd3, r);
    vec++; if (r !== exp_hi) begin errs++; $display("FAIL div_rd_hi got %h want %h", r, exp_hi); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] r;
    iocs = 1; iorw = 1; ioaddr = 2'd1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    vec++; if (databus !== 8'h00) begin errs++; $display("FAIL abort_bus got %h want 00", databus); end
    vec++; if (baud_div !== 16'h0145) begin errs++; $display("FAIL abort_div got %h want 0145", baud_div); end
    tick();
    iocs = 0; iorw = 0;
    tick();
    bus_read(2'd1, r);
    vec++; if (r !== 8'h06) begin errs++; $display("FAIL abort_status got %h want 06", r); end
  endtask

  initial begin
    test_reset();
    test_rx_read();
    test_tx_overflow();
    test_back_to_back();
    test_rx_full();
    test_baud();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
